// File: rtl/dma_addr_count_unit.sv
// Per-channel address/word-count engine: CPU-programmable base/current registers,
// step-driven address generation with ADSTB, terminal count and autoinitialize.
module dma_addr_count_unit #(
   parameter int NCH = 4,
   parameter int AW  = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           prog_wr,
   input  logic           prog_rd,
   input  logic [3:0]     prog_addr,
   input  logic           clear_ff,
   input  logic [7:0]     din,
   output logic [7:0]     dout,
   input  logic           xfer_start,
   input  logic [1:0]     ch_sel,
   input  logic           step,
   input  logic [NCH-1:0] mode_dec,
   input  logic [NCH-1:0] mode_auto,
   output logic [AW-1:0]  addr_out,
   output logic           adstb,
   output logic           tc,
   output logic [1:0]     tc_ch,
   output logic [NCH-1:0] done
);

   logic          ff_reg;
   logic          first_pend_reg;
   logic          wr_acc;
   logic          rd_acc;
   logic          step_eff;
   logic [AW-1:0] cur_addr_w [NCH];
   logic [AW-1:0] cur_cnt_w  [NCH];
   logic [NCH-1:0] done_w;
   logic [AW-1:0] sel_addr;
   logic [AW-1:0] rd_word;
   logic [7:0]    rd_byte;

   // Registers with prog_addr[3] set do not exist: no access, no ff toggle.
   assign wr_acc   = prog_wr && !prog_addr[3];
   assign rd_acc   = prog_rd && !prog_addr[3];
   assign step_eff = step && !wr_acc && !done_w[ch_sel];
   assign sel_addr = cur_addr_w[ch_sel];
   assign rd_word  = prog_addr[0] ? cur_cnt_w[prog_addr[2:1]] : cur_addr_w[prog_addr[2:1]];
   assign rd_byte  = ff_reg ? rd_word[AW-1:8] : rd_word[7:0];
   assign done     = done_w;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [AW-1:0] base_addr_reg;
         logic [AW-1:0] cur_addr_reg;
         logic [AW-1:0] base_cnt_reg;
         logic [AW-1:0] cur_cnt_reg;
         logic          done_reg;
         logic          wr_me;
         logic          step_me;

         assign wr_me   = wr_acc && (prog_addr[2:1] == 2'(gi));
         assign step_me = step_eff && (ch_sel == 2'(gi));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               base_addr_reg <= '0;
               cur_addr_reg  <= '0;
               base_cnt_reg  <= '0;
               cur_cnt_reg   <= '0;
               done_reg      <= 1'b0;
            end else if (wr_me) begin
               // Writes land in base and current together.
               if (!prog_addr[0]) begin
                  if (ff_reg) begin
                     base_addr_reg[AW-1:8] <= din;
                     cur_addr_reg[AW-1:8]  <= din;
                  end else begin
                     base_addr_reg[7:0] <= din;
                     cur_addr_reg[7:0]  <= din;
                  end
               end else begin
                  if (ff_reg) begin
                     base_cnt_reg[AW-1:8] <= din;
                     cur_cnt_reg[AW-1:8]  <= din;
                  end else begin
                     base_cnt_reg[7:0] <= din;
                     cur_cnt_reg[7:0]  <= din;
                  end
                  done_reg <= 1'b0;
               end
            end else if (step_me) begin
               if (cur_cnt_reg == '0 && mode_auto[gi]) begin
                  cur_addr_reg <= base_addr_reg;
                  cur_cnt_reg  <= base_cnt_reg;
               end else begin
                  cur_addr_reg <= mode_dec[gi] ? cur_addr_reg - AW'(1) : cur_addr_reg + AW'(1);
                  cur_cnt_reg  <= cur_cnt_reg - AW'(1);
                  if (cur_cnt_reg == '0) begin
                     done_reg <= 1'b1;
                  end
               end
            end
         end

         assign cur_addr_w[gi] = cur_addr_reg;
         assign cur_cnt_w[gi]  = cur_cnt_reg;
         assign done_w[gi]     = done_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ff_reg         <= 1'b0;
         first_pend_reg <= 1'b0;
         dout           <= '0;
         addr_out       <= '0;
         adstb          <= 1'b0;
         tc             <= 1'b0;
         tc_ch          <= '0;
      end else begin
         if (clear_ff) begin
            ff_reg <= 1'b0;
         end else if (wr_acc || rd_acc) begin
            ff_reg <= ~ff_reg;
         end

         if (rd_acc && !wr_acc) begin
            dout <= rd_byte;
         end

         adstb <= 1'b0;
         tc    <= 1'b0;
         if (step_eff) begin
            addr_out       <= sel_addr;
            adstb          <= first_pend_reg || xfer_start ||
                              (sel_addr[AW-1:8] != addr_out[AW-1:8]);
            tc             <= (cur_cnt_w[ch_sel] == '0);
            tc_ch          <= ch_sel;
            first_pend_reg <= 1'b0;
         end else if (xfer_start) begin
            first_pend_reg <= 1'b1;
         end
      end
   end

endmodule
